// File: rtl/spi_burst_arb.sv
`default_nettype none
// ============================================================================
// Module   : spi_burst_arb
// Purpose  : Two-requester round-robin arbiter and burst sequencer in front of
//            a byte-level SPI master. A granted requester's N-byte burst is
//            issued as N back-to-back single-byte transfers; TX bytes are
//            pulled with tx_pop and each received byte is returned with
//            rx_valid. Owns the master's ready_send/busy handshake.
// Options  : define SPI_ARB_WDOG_EN to enable the transfer watchdog
//            (abort with err/done and a one-cycle spi_rst pulse).
// Revision : 1.0 - initial release
// ============================================================================
module spi_burst_arb #(
  parameter int LEN_W    = 4,
  parameter int WDOG_CYC = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len_0,
  input  logic [LEN_W-1:0] len_1,
  input  logic [7:0]       tx_data_0,
  input  logic [7:0]       tx_data_1,
  output logic [1:0]       tx_pop,
  output logic [7:0]       rx_data,
  output logic [1:0]       rx_valid,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [1:0]       err,
  output logic [7:0]       spi_data_in,
  output logic             spi_ready_send,
  output logic             spi_rst,
  input  logic             spi_busy,
  input  logic [7:0]       spi_data_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARB       = 3'd1,
    LOAD      = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    FIN       = 3'd5
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             last_q, last_d;        // 1: requester 1 was granted last
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [7:0]       spi_data_in_q, spi_data_in_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic [1:0]       rx_valid_q, rx_valid_d;

  logic [1:0]       w_elig;               // pending requests with a non-zero length
  logic [1:0]       w_win;                // arbitration winner (one-hot)

`ifdef SPI_ARB_WDOG_EN
  localparam int             WD_MAX    = (WDOG_CYC > 4) ? WDOG_CYC : 4;
  localparam int             CNT_W     = $clog2(WD_MAX + 1);
  localparam logic [CNT_W-1:0] BUSY_LIM = CNT_W'(4);
  localparam logic [CNT_W-1:0] DONE_LIM = CNT_W'(WDOG_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;         // cycles spent in the current wait state
  logic             abort_q, abort_d;     // high only in the FIN cycle of an aborted burst
`else
  logic             w_unused_wdog;
  assign w_unused_wdog = ^WDOG_CYC;
`endif

  // A zero-length request is never eligible, so remaining can never wrap
  assign w_elig = {req[1] & (|len_1), req[0] & (|len_0)};

  // Next-state, arbitration and datapath updates
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_d        = last_q;
    remaining_d   = remaining_q;
    spi_data_in_d = spi_data_in_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 2'b00;
    w_win         = 2'b00;
`ifdef SPI_ARB_WDOG_EN
    cnt_d         = '0;
    abort_d       = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (|w_elig) state_d = ARB;
      end

      ARB: begin
        // On a tie the requester not granted last wins
        if (w_elig == 2'b11) w_win = last_q ? 2'b01 : 2'b10;
        else                 w_win = w_elig;
        if (|w_elig) begin
          gnt_d         = w_win;
          remaining_d   = w_win[1] ? len_1 : len_0;
          spi_data_in_d = w_win[1] ? tx_data_1 : tx_data_0;
          state_d       = LOAD;
        end else begin
          // Request withdrawn between IDLE and ARB
          state_d = IDLE;
        end
      end

      LOAD: begin
        state_d = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        if (spi_busy) state_d = WAIT_DONE;
`ifdef SPI_ARB_WDOG_EN
        else if (cnt_q == BUSY_LIM) begin
          state_d = FIN;
          abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`endif
      end

      WAIT_DONE: begin
        if (!spi_busy) begin
          rx_data_d   = spi_data_out;
          rx_valid_d  = gnt_q;
          remaining_d = remaining_q - LEN_ONE;
          if (remaining_q != LEN_ONE) begin
            spi_data_in_d = gnt_q[1] ? tx_data_1 : tx_data_0;
            state_d       = LOAD;
          end else begin
            state_d = FIN;
          end
        end
`ifdef SPI_ARB_WDOG_EN
        else if (cnt_q == DONE_LIM) begin
          state_d = FIN;
          abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`endif
      end

      FIN: begin
        gnt_d   = 2'b00;
        last_d  = gnt_q[1];
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gnt_q         <= 2'b00;
      last_q        <= 1'b1;
      remaining_q   <= '0;
      spi_data_in_q <= 8'h00;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 2'b00;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      last_q        <= last_d;
      remaining_q   <= remaining_d;
      spi_data_in_q <= spi_data_in_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
    end
  end

`ifdef SPI_ARB_WDOG_EN
  // Watchdog counter and abort flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign err     = abort_q ? gnt_q : 2'b00;
  assign spi_rst = !rst_n | abort_q;
`else
  assign err     = 2'b00;
  assign spi_rst = !rst_n;
`endif

  // Strobes decoded from the registered state
  assign gnt            = gnt_q;
  assign spi_ready_send = (state_q == LOAD);
  assign tx_pop         = (state_q == LOAD) ? gnt_q : 2'b00;
  assign done           = (state_q == FIN) ? gnt_q : 2'b00;
  assign spi_data_in    = spi_data_in_q;
  assign rx_data        = rx_data_q;
  assign rx_valid       = rx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_burst_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_burst_arb
// Purpose  : Directed self-checking bench for spi_burst_arb with a simple
//            loop-back SPI master model. The watchdog scenario is built only
//            when SPI_ARB_WDOG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_burst_arb;

  localparam int LEN_W = 4;
  localparam int WDOG  = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req;
  logic [LEN_W-1:0] len_0, len_1;
  logic [7:0]       tx_data_0, tx_data_1;
  logic [1:0]       tx_pop, rx_valid, gnt, done, err;
  logic [7:0]       rx_data, spi_data_in, spi_data_out;
  logic             spi_ready_send, spi_rst, spi_busy;

  int n_chk  = 0;
  int n_fail = 0;

  // Monitor counters (written only by the monitor process)
  int pop0 = 0, pop1 = 0, rxv0 = 0, rxv1 = 0, done0 = 0, done1 = 0;
  int ndone = 0, rs_cnt = 0, gnt_seen = 0, viol = 0;
  logic rs_prev = 1'b0;
  logic [7:0] rxlog0 [0:63];
  logic [7:0] rxlog1 [0:63];
  int         ordlog [0:63];

  // Requester TX byte streams, advanced by tx_pop
  logic [7:0] tx0 [0:7];
  logic [7:0] tx1 [0:7];
  int base0 = 0, base1 = 0;
  logic hang = 1'b0;

  assign tx_data_0 = tx0[3'(pop0 - base0)];
  assign tx_data_1 = tx1[3'(pop1 - base1)];

  always #5 clk = ~clk;

  spi_burst_arb #(.LEN_W(LEN_W), .WDOG_CYC(WDOG)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .len_0          (len_0),
    .len_1          (len_1),
    .tx_data_0      (tx_data_0),
    .tx_data_1      (tx_data_1),
    .tx_pop         (tx_pop),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .gnt            (gnt),
    .done           (done),
    .err            (err),
    .spi_data_in    (spi_data_in),
    .spi_ready_send (spi_ready_send),
    .spi_rst        (spi_rst),
    .spi_busy       (spi_busy),
    .spi_data_out   (spi_data_out)
  );

  // Loop-back SPI master: busy one cycle after the strobe, returns the sent byte
  initial begin
    logic [7:0] d;
    int k;
    spi_busy     = 1'b0;
    spi_data_out = 8'h00;
    forever begin
      @(posedge clk); #2;
      if (spi_ready_send && !spi_rst) begin
        d = spi_data_in;
        @(posedge clk); #2;
        spi_busy = 1'b1;
        k = 0;
        while ((hang || k < 3) && !spi_rst) begin
          @(posedge clk); #2;
          k++;
        end
        spi_data_out = d;
        spi_busy     = 1'b0;
      end
    end
  end

  // Event monitor, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (tx_pop[0]) pop0++;
      if (tx_pop[1]) pop1++;
      if (rx_valid[0]) begin rxlog0[rxv0 & 63] = rx_data; rxv0++; end
      if (rx_valid[1]) begin rxlog1[rxv1 & 63] = rx_data; rxv1++; end
      if (done[0]) begin ordlog[ndone & 63] = 0; ndone++; done0++; end
      if (done[1]) begin ordlog[ndone & 63] = 1; ndone++; done1++; end
      if (spi_ready_send) rs_cnt++;
      if (spi_ready_send && (spi_busy || rs_prev)) viol++;
      rs_prev = spi_ready_send;
      if (gnt != 2'b00) gnt_seen++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Hold the requests in r until each requester has seen n_each done pulses
  task automatic serve(input logic [1:0] r, input int n_each);
    int c0, c1, n;
    c0 = 0; c1 = 0; n = 0;
    req = r;
    while (req != 2'b00 && n < 400) begin
      tick();
      n++;
      if (done[0]) begin c0++; if (c0 >= n_each) req[0] = 1'b0; end
      if (done[1]) begin c1++; if (c1 >= n_each) req[1] = 1'b0; end
    end
    chk("serve_end", 32'(req), 32'h0);
  endtask

  initial begin
    int n, s_pop, s_rxv, s_done, s_nd, s_rx0, s_rx1, s_rs, s_g;
    rst_n = 1'b0;
    req   = 2'b00;
    len_0 = '0;
    len_1 = '0;
    for (int i = 0; i < 8; i++) begin
      tx0[i] = 8'h00;
      tx1[i] = 8'h00;
    end
    repeat (3) tick();

    // Reset state
    chk("rst_gnt",      32'(gnt),            32'h0);
    chk("rst_tx_pop",   32'(tx_pop),         32'h0);
    chk("rst_rx_valid", 32'(rx_valid),       32'h0);
    chk("rst_done",     32'(done),           32'h0);
    chk("rst_err",      32'(err),            32'h0);
    chk("rst_ready",    32'(spi_ready_send), 32'h0);
    chk("rst_data_in",  32'(spi_data_in),    32'h0);
    chk("rst_rx_data",  32'(rx_data),        32'h0);
    chk("rst_spi_rst",  32'(spi_rst),        32'h1);
    rst_n = 1'b1;
    tick();
    chk("rel_spi_rst",  32'(spi_rst),        32'h0);

    // Three-byte burst on requester 0
    tx0[0] = 8'hA5; tx0[1] = 8'h3C; tx0[2] = 8'hFF;
    base0 = pop0;
    len_0 = 4'd3;
    s_pop = pop0; s_rxv = rxv0; s_done = done0;
    req[0] = 1'b1;
    n = 0;
    while (!spi_ready_send && n < 20) begin tick(); n++; end
    chk("latency",   32'(n),           32'd2);
    chk("load_data", 32'(spi_data_in), 32'hA5);
    chk("load_pop",  32'(tx_pop),      32'h1);
    chk("gnt0",      32'(gnt),         32'h1);
    n = 0;
    while (!done[0] && n < 200) begin tick(); n++; end
    chk("fin_done",  32'(done),     32'h1);
    chk("fin_rxv",   32'(rx_valid), 32'h1);
    chk("fin_rxd",   32'(rx_data),  32'hFF);
    req[0] = 1'b0;
    repeat (4) tick();
    chk("b3_pops",  32'(pop0 - s_pop),   32'd3);
    chk("b3_rxv",   32'(rxv0 - s_rxv),   32'd3);
    chk("b3_done",  32'(done0 - s_done), 32'd1);
    chk("b3_rx0",   32'(rxlog0[(s_rxv + 0) & 63]), 32'hA5);
    chk("b3_rx1",   32'(rxlog0[(s_rxv + 1) & 63]), 32'h3C);
    chk("b3_rx2",   32'(rxlog0[(s_rxv + 2) & 63]), 32'hFF);
    chk("b3_idle",  32'(gnt), 32'h0);

    // Round-robin: simultaneous requests after reset, then alternation
    do_reset();
    tx0[0] = 8'h11; tx0[1] = 8'h33; tx0[2] = 8'h55; tx0[3] = 8'h77;
    tx1[0] = 8'h22; tx1[1] = 8'h44; tx1[2] = 8'h66; tx1[3] = 8'h88;
    base0 = pop0; base1 = pop1;
    len_0 = 4'd1; len_1 = 4'd1;
    s_nd = ndone; s_rx0 = rxv0; s_rx1 = rxv1;
    serve(2'b11, 1);
    serve(2'b11, 1);
    serve(2'b11, 2);
    repeat (3) tick();
    chk("rr_count", 32'(ndone - s_nd), 32'd8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("rr_order%0d", k), 32'(ordlog[(s_nd + k) & 63]), 32'(k % 2));
    chk("rr_rx1_first", 32'(rxlog1[(s_rx1 + 0) & 63]), 32'h22);
    chk("rr_rx0_last",  32'(rxlog0[(s_rx0 + 3) & 63]), 32'h77);
    chk("rr_rx1_last",  32'(rxlog1[(s_rx1 + 3) & 63]), 32'h88);

    // Zero-length request is never granted
    len_1 = 4'd0;
    s_rs = rs_cnt; s_g = gnt_seen;
    req = 2'b10;
    repeat (50) tick();
    chk("len0_ready", 32'(rs_cnt - s_rs),   32'd0);
    chk("len0_gnt",   32'(gnt_seen - s_g),  32'd0);
    req = 2'b00;
    tick();

    // Reset during byte 2 of a four-byte burst
    tx0[0] = 8'h01; tx0[1] = 8'h02; tx0[2] = 8'h03; tx0[3] = 8'h04;
    base0 = pop0;
    len_0 = 4'd4;
    s_pop = pop0; s_done = done0;
    req = 2'b01;
    n = 0;
    while ((pop0 - s_pop) < 2 && n < 100) begin tick(); n++; end
    chk("mid_reach", 32'(pop0 - s_pop), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_spi_rst", 32'(spi_rst), 32'h1);
    tick();
    chk("mid_gnt",     32'(gnt),            32'h0);
    chk("mid_ready",   32'(spi_ready_send), 32'h0);
    chk("mid_done",    32'(done),           32'h0);
    chk("mid_spi_rst2",32'(spi_rst),        32'h1);
    req = 2'b00;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("mid_no_done", 32'(done0 - s_done), 32'd0);
    chk("mid_idle",    32'(gnt),            32'h0);

    // Dropping req and changing len mid-burst do not affect the burst
    tx0[0] = 8'h5A; tx0[1] = 8'hC3;
    base0 = pop0;
    len_0 = 4'd2;
    s_pop = pop0; s_rxv = rxv0; s_done = done0;
    req = 2'b01;
    n = 0;
    while ((pop0 - s_pop) < 1 && n < 100) begin tick(); n++; end
    len_0 = 4'd9;
    n = 0;
    while ((rxv0 - s_rxv) < 1 && n < 100) begin tick(); n++; end
    req[0] = 1'b0;
    n = 0;
    while ((done0 - s_done) < 1 && n < 200) begin tick(); n++; end
    repeat (4) tick();
    chk("drop_pops", 32'(pop0 - s_pop),   32'd2);
    chk("drop_rxv",  32'(rxv0 - s_rxv),   32'd2);
    chk("drop_done", 32'(done0 - s_done), 32'd1);
    chk("drop_rx1",  32'(rxlog0[(s_rxv + 1) & 63]), 32'hC3);
    len_0 = 4'd0;

`ifdef SPI_ARB_WDOG_EN
    // Watchdog: busy never falls
    tx0[0] = 8'h99;
    base0 = pop0;
    len_0 = 4'd1;
    hang  = 1'b1;
    req   = 2'b01;
    n = 0;
    while (!spi_ready_send && n < 20) begin tick(); n++; end
    n = 0;
    while (!done[0] && n < 200) begin tick(); n++; end
    chk("wdog_lat",     32'(n),       32'(WDOG + 3));
    chk("wdog_err",     32'(err),     32'h1);
    chk("wdog_done",    32'(done),    32'h1);
    chk("wdog_spi_rst", 32'(spi_rst), 32'h1);
    req  = 2'b00;
    hang = 1'b0;
    repeat (5) tick();
    chk("wdog_clear",   32'(err),     32'h0);
    len_0 = 4'd0;
`endif

    chk("strobe_rule", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
